// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one single-cycle ALU between two valid/ready requesters, one response register per port.
// Define ALU_ARB_RR_EN for round-robin conflict resolution; otherwise port 0 has fixed priority.
module alu_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 4
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  req0_valid,
  input  logic [OP_WIDTH-1:0]   req0_aluop,
  input  logic [DATA_WIDTH-1:0] req0_port_a,
  input  logic [DATA_WIDTH-1:0] req0_port_b,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [OP_WIDTH-1:0]   req1_aluop,
  input  logic [DATA_WIDTH-1:0] req1_port_a,
  input  logic [DATA_WIDTH-1:0] req1_port_b,
  output logic                  req1_ready,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_data,
  input  logic                  rsp0_ready,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_data,
  input  logic                  rsp1_ready,
  output logic [OP_WIDTH-1:0]   alu_aluop,
  output logic [DATA_WIDTH-1:0] alu_port_a,
  output logic [DATA_WIDTH-1:0] alu_port_b,
  input  logic [DATA_WIDTH-1:0] alu_port_out,
  output logic [31:0]           busy_cnt
);

  logic                  w_slot_free0;
  logic                  w_slot_free1;
  logic                  w_elig0;
  logic                  w_elig1;
  logic                  w_fav0;
  logic                  w_fire0;
  logic                  w_fire1;
  logic                  r_rsp0_valid;
  logic                  r_rsp1_valid;
  logic [DATA_WIDTH-1:0] r_rsp0_data;
  logic [DATA_WIDTH-1:0] r_rsp1_data;
  logic [31:0]           r_busy_cnt;

  // A slot being drained this cycle can be refilled in the same cycle.
  assign w_slot_free0 = !r_rsp0_valid | rsp0_ready;
  assign w_slot_free1 = !r_rsp1_valid | rsp1_ready;
  assign w_elig0      = req0_valid & w_slot_free0;
  assign w_elig1      = req1_valid & w_slot_free1;

  // Ready looks only at the other port's eligibility, never at this port's own valid.
  assign req0_ready   = w_slot_free0 & (!w_elig1 | w_fav0);
  assign req1_ready   = w_slot_free1 & (!w_elig0 | !w_fav0);
  assign w_fire0      = req0_valid & req0_ready;
  assign w_fire1      = req1_valid & req1_ready;

`ifdef ALU_ARB_RR_EN
  logic r_last_grant;

  assign w_fav0 = r_last_grant;

  // Round-robin pointer: remembers the most recently granted port.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_last_grant <= 1'b1;
    end else if (w_fire0) begin
      r_last_grant <= 1'b0;
    end else if (w_fire1) begin
      r_last_grant <= 1'b1;
    end else begin
      r_last_grant <= r_last_grant;
    end
  end
`else
  assign w_fav0 = 1'b1;
`endif

  // Steer the granted port's operation onto the shared ALU; idle cycles drive zeros.
  always_comb begin
    alu_aluop  = {OP_WIDTH{1'b0}};
    alu_port_a = {DATA_WIDTH{1'b0}};
    alu_port_b = {DATA_WIDTH{1'b0}};
    if (w_fire0) begin
      alu_aluop  = req0_aluop;
      alu_port_a = req0_port_a;
      alu_port_b = req0_port_b;
    end else if (w_fire1) begin
      alu_aluop  = req1_aluop;
      alu_port_a = req1_port_a;
      alu_port_b = req1_port_b;
    end else begin
      alu_aluop  = {OP_WIDTH{1'b0}};
      alu_port_a = {DATA_WIDTH{1'b0}};
      alu_port_b = {DATA_WIDTH{1'b0}};
    end
  end

  // Port 0 response register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_rsp0_valid <= 1'b0;
      r_rsp0_data  <= {DATA_WIDTH{1'b0}};
    end else if (w_fire0) begin
      r_rsp0_valid <= 1'b1;
      r_rsp0_data  <= alu_port_out;
    end else if (rsp0_ready) begin
      r_rsp0_valid <= 1'b0;
    end else begin
      r_rsp0_valid <= r_rsp0_valid;
    end
  end

  // Port 1 response register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_rsp1_valid <= 1'b0;
      r_rsp1_data  <= {DATA_WIDTH{1'b0}};
    end else if (w_fire1) begin
      r_rsp1_valid <= 1'b1;
      r_rsp1_data  <= alu_port_out;
    end else if (rsp1_ready) begin
      r_rsp1_valid <= 1'b0;
    end else begin
      r_rsp1_valid <= r_rsp1_valid;
    end
  end

  // Utilisation counter, wraps naturally.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_busy_cnt <= 32'd0;
    end else if (w_fire0 | w_fire1) begin
      r_busy_cnt <= r_busy_cnt + 32'd1;
    end else begin
      r_busy_cnt <= r_busy_cnt;
    end
  end

  assign rsp0_valid = r_rsp0_valid;
  assign rsp0_data  = r_rsp0_data;
  assign rsp1_valid = r_rsp1_valid;
  assign rsp1_data  = r_rsp1_data;
  assign busy_cnt   = r_busy_cnt;

endmodule
